divider: RTL and testbench

- Multicycle RV32M divide unit; the inverse-operation companion to the core's multicycle multiplier.
- Executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per enabled clock.
- Sits in the execute stage beside the multiplier and uses the same valid/ready/ce handshake, so the core's control FSM treats both units identically.

---
 rtl/riscv_div_pkg.sv | 28 ++
 rtl/divider_if.sv | 24 ++
 rtl/divider_step.sv | 25 ++
 rtl/divider.sv | 132 +++++++++++++
 tb/tb_divider.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_div_pkg.sv
// rtl/riscv_div_pkg.sv - shared constants for the RV32M multicycle divider
// Purpose: DIVop encodings, one-hot FSM state bit indices/values, iteration count.
// Ports: none (package).
package riscv_div_pkg;

  // funct3[1:0] encodings carried on DIVop
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  // one quotient bit per iteration
  localparam int ITER_CNT = 32;

  // one-hot state bit indices
  localparam int S_IDLE  = 0;
  localparam int S_CALC  = 1;
  localparam int S_FIX   = 2;
  localparam int S_READY = 3;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'b0001;
  localparam state_t ST_CALC  = 4'b0010;
  localparam state_t ST_FIX   = 4'b0100;
  localparam state_t ST_READY = 4'b1000;

endpackage

// File: rtl/divider_if.sv
// rtl/divider_if.sv - request/response bundle between the core and the divide unit
// Purpose: groups ce, operands, DIVop, valid, result and ready.
// Ports: master = core side (drives ce/operands/DIVop/valid), slave = divider (drives result/ready).
interface divider_if #(
  parameter int XLEN = 32
);
  logic            ce;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [1:0]      DIVop;
  logic            valid;
  logic [XLEN-1:0] result;
  logic            ready;

  modport master (
    output ce, dividend, divisor, DIVop, valid,
    input  result, ready
  );

  modport slave (
    input  ce, dividend, divisor, DIVop, valid,
    output result, ready
  );
endinterface

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one radix-2 restoring division iteration
// Purpose: shifts the next dividend bit into the partial remainder and trial-subtracts the divisor.
// Ports: rem (partial remainder), q_msb (next dividend bit), dsr (divisor magnitude)
//        -> rem_next (updated remainder), q_bit (quotient bit produced).
module divider_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            q_msb,
  input  logic [XLEN-1:0] dsr,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Full width shifted value keeps rem[XLEN-1]: with a divisor above 2^(XLEN-1)
  // the partial remainder can have its top bit set and must not be dropped.
  always_comb begin
    shifted  = {rem, q_msb};
    trial    = shifted - {1'b0, dsr};
    q_bit    = ~trial[XLEN];
    rem_next = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end
endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multicycle RV32M divide unit (DIV, DIVU, REM, REMU)
// Purpose: radix-2 restoring divider, one quotient bit per enabled clock, sign fix-up after.
//          Optional macro DIV_FAST_PATH_EN: divide-by-zero, signed overflow and divide-by-one
//          complete straight from IDLE in two enabled edges.
// Ports: clk, reset (async, active-high), bus (divider_if.slave: ce, dividend, divisor,
//        DIVop, valid in; result, ready out).
module divider
  import riscv_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      reset,
  divider_if.slave  bus
);
  state_t          state, state_next;
  logic [XLEN-1:0] q, rem, dsr;
  logic [4:0]      count;
  logic            neg_q, neg_r, ready_r;

  logic            is_signed;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] step_rem;
  logic            step_bit;
  logic            accept;

  assign is_signed = ~bus.DIVop[0];
  assign abs_a     = (is_signed && bus.dividend[XLEN-1]) ? -bus.dividend : bus.dividend;
  assign abs_b     = (is_signed && bus.divisor[XLEN-1])  ? -bus.divisor  : bus.divisor;
  // ready_r is still high on the cycle after completion; blocks re-accepting the held request
  assign accept    = bus.valid && !ready_r;

  divider_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .q_msb    (q[XLEN-1]),
    .dsr      (dsr),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

`ifdef DIV_FAST_PATH_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_q, fast_r;

  always_comb begin
    fast_hit = 1'b0;
    fast_q   = '0;
    fast_r   = '0;
    if (bus.divisor == '0) begin
      fast_hit = 1'b1;
      fast_q   = '1;
      fast_r   = bus.dividend;
    end else if (is_signed && bus.dividend == {1'b1, {(XLEN-1){1'b0}}} && bus.divisor == '1) begin
      fast_hit = 1'b1;
      fast_q   = bus.dividend;
    end else if (bus.divisor == {{(XLEN-1){1'b0}}, 1'b1}) begin
      fast_hit = 1'b1;
      fast_q   = bus.dividend;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else if (bus.ce) state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef DIV_FAST_PATH_EN
          state_next = fast_hit ? ST_READY : ST_CALC;
`else
          state_next = ST_CALC;
`endif
        end
      end
      ST_CALC:  if (count == 5'd0) state_next = ST_FIX;
      ST_FIX:   state_next = ST_READY;
      ST_READY: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= '0;
      rem     <= '0;
      dsr     <= '0;
      count   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      ready_r <= 1'b0;
    end else if (bus.ce) begin
      if (state[S_IDLE]) begin
        ready_r <= 1'b0;
        if (accept) begin
          q     <= abs_a;
          rem   <= '0;
          dsr   <= abs_b;
          count <= 5'(ITER_CNT - 1);
          // divide-by-zero keeps the all-ones quotient; remainder sign restores the dividend
          neg_q <= is_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]) && (bus.divisor != '0);
          neg_r <= is_signed && bus.dividend[XLEN-1];
`ifdef DIV_FAST_PATH_EN
          if (fast_hit) begin
            q   <= fast_q;
            rem <= fast_r;
          end
`endif
        end
      end
      if (state[S_CALC]) begin
        rem   <= step_rem;
        q     <= {q[XLEN-2:0], step_bit};
        count <= count - 5'd1;
      end
      if (state[S_FIX]) begin
        if (neg_q) q   <= -q;
        if (neg_r) rem <= -rem;
      end
      if (state[S_READY]) ready_r <= 1'b1;
    end
  end

  always_comb begin
    bus.result = bus.DIVop[1] ? rem : q;
    bus.ready  = ready_r;
  end
endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard bench for the RV32M divider
module tb_divider;
  import riscv_div_pkg::*;

  typedef struct {
    logic [31:0] exp;
    int          exp_lat;
    int          accept_idx;
    string       name;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  divider_if bus();

  divider dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  item_t sb[$];
  item_t mon_it;
  int    n_pass = 0;
  int    n_total = 0;
  int    en_cnt = 0;
  int    done_cnt = 0;
  int    last_ready_cnt = -1;
  bit    ce_toggle = 1'b0;

  always @(posedge clk) if (bus.ce === 1'b1) en_cnt = en_cnt + 1;

  always @(negedge clk) begin
    if (ce_toggle) bus.ce = ~bus.ce;
    else bus.ce = 1'b1;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_model(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    logic [31:0] qv, rv;
    int ia, ib;
    if (b == 32'd0) begin
      qv = 32'hFFFFFFFF; rv = a;
    end else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      qv = 32'h80000000; rv = 32'd0;
    end else if (!op[0]) begin
      ia = a; ib = b;
      qv = ia / ib; rv = ia % ib;
    end else begin
      qv = a / b; rv = a % b;
    end
    return op[1] ? rv : qv;
  endfunction

  function automatic int exp_latency(logic [31:0] a, logic [31:0] b, logic [1:0] op);
`ifdef DIV_FAST_PATH_EN
    if (b == 32'd0 || b == 32'd1 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 2;
`endif
    return 35;
  endfunction

  // Monitor: a new enabled edge with ready high is a new completion
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.ready === 1'b1 && en_cnt != last_ready_cnt) begin
      last_ready_cnt = en_cnt;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ready: result %h with nothing outstanding", bus.result);
      end else begin
        mon_it = sb.pop_front();
        check(mon_it.name, bus.result, mon_it.exp);
        check({mon_it.name, "_lat"}, en_cnt - mon_it.accept_idx + 1, mon_it.exp_lat);
        done_cnt++;
      end
    end
  end

  task automatic run_op(logic [31:0] a, logic [31:0] b, logic [1:0] op, string name);
    item_t it;
    int t;
    int target;
    t = 0;
    while (bus.ready !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    bus.dividend = a;
    bus.divisor  = b;
    bus.DIVop    = op;
    bus.valid    = 1'b1;
    do @(posedge clk); while (bus.ce !== 1'b1);
    #1;
    it.accept_idx = en_cnt;
    it.exp        = ref_model(a, b, op);
    it.exp_lat    = exp_latency(a, b, op);
    it.name       = name;
    target        = done_cnt + 1;
    sb.push_back(it);
    t = 0;
    while (done_cnt < target && t < 400) begin @(negedge clk); t++; end
    if (done_cnt < target) begin
      n_total++;
      $display("FAIL %s_timeout: no ready within %0d cycles, expected result %h", name, t, it.exp);
      sb.delete();
    end
    bus.valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    unique case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    reset        = 1'b1;
    bus.valid    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    bus.DIVop    = DIV_OP_DIV;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, bus.ready}, 32'd0);
    check("reset_result_q", bus.result, 32'd0);
    bus.DIVop = DIV_OP_REM;
    #1;
    check("reset_result_r", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(32'd100, 32'd7, DIV_OP_DIVU, "divu_100_7");
    run_op(32'd100, 32'd7, DIV_OP_REMU, "remu_100_7");
    run_op(-32'sd7, 32'd2, DIV_OP_DIV,  "div_m7_2");
    run_op(-32'sd7, 32'd2, DIV_OP_REM,  "rem_m7_2");
    run_op(32'd7, -32'sd2, DIV_OP_REM,  "rem_7_m2");
    run_op(32'd5, 32'd0,   DIV_OP_DIV,  "div_5_0");
    run_op(-32'sd5, 32'd0, DIV_OP_REM,  "rem_m5_0");
    run_op(32'd0, 32'd0,   DIV_OP_DIVU, "divu_0_0");
    run_op(32'h80000000, 32'hFFFFFFFF, DIV_OP_DIV, "div_ovf");
    run_op(32'h80000000, 32'hFFFFFFFF, DIV_OP_REM, "rem_ovf");
    run_op(32'd1234, 32'd1, DIV_OP_DIVU, "divu_1234_1");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFE, DIV_OP_REMU, "remu_big");

    ce_toggle = 1'b1;
    run_op(32'hFFFFFFFF, 32'd3, DIV_OP_DIVU, "divu_ce_toggle");
    ce_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of an iteration run
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    bus.DIVop    = DIV_OP_DIVU;
    bus.valid    = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    bus.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_no_pulse", {31'd0, bus.ready}, 32'd0);
    run_op(32'd1000, 32'd3, DIV_OP_DIVU, "after_abort");

    for (int i = 0; i < 40; i++) begin
      ra  = rand_operand();
      rb  = rand_operand();
      rop = 2'($urandom_range(0, 3));
      run_op(ra, rb, rop, $sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb));
    end

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
